// File: rtl/fpu_sched_pkg.sv
// Shared definitions for the FPU issue/writeback scheduler:
// op encoding, latency lookup and the reservation slot record.
package fpu_sched_pkg;

  typedef enum logic [2:0] {
    OP_FADD    = 3'd0,
    OP_FSUB    = 3'd1,
    OP_FMUL    = 3'd2,
    OP_FDIV    = 3'd3,
    OP_FISZERO = 3'd4,
    OP_FISPOS  = 3'd5,
    OP_FISNEG  = 3'd6,
    OP_ILLEGAL = 3'd7
  } fp_op_e;

  // The destination tag travels alongside the record in the ring, since its width is a parameter.
  typedef struct packed {
    logic       valid;
    logic       illegal;
    logic [2:0] op;
  } slot_t;

  function automatic logic [3:0] op_latency(input logic [2:0] op,
                                            input int lat_cmp,
                                            input int lat_add,
                                            input int lat_mul,
                                            input int lat_div);
    int l;
    case (op)
      OP_FADD, OP_FSUB:                  l = lat_add;
      OP_FMUL:                           l = lat_mul;
      OP_FDIV:                           l = lat_div;
      OP_FISZERO, OP_FISPOS, OP_FISNEG:  l = lat_cmp;
      default:                           l = 1;
    endcase
    return 4'(l);
  endfunction

endpackage

// File: rtl/fpu_resv_ring.sv
// Writeback reservation ring: slots 1..D shift toward slot 1 every cycle,
// a new entry lands in slot[L]; slot D+1 reads as permanently empty.
module fpu_resv_ring
  import fpu_sched_pkg::*;
#(
  parameter int D     = 8,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ins_en,
  input  logic [3:0]       ins_lat,
  input  slot_t            ins_slot,
  input  logic [TAG_W-1:0] ins_tag,
  input  logic [3:0]       chk_lat,
  output logic             chk_free,
  output slot_t            head_slot,
  output logic [TAG_W-1:0] head_tag,
  output logic             any_valid
);

  slot_t            slots [1:D];
  logic [TAG_W-1:0] tags  [1:D];
  slot_t            ext_slots [1:D+1];
  logic [TAG_W-1:0] ext_tags  [1:D+1];

  always_comb begin
    for (int k = 1; k <= D; k++) begin
      ext_slots[k] = slots[k];
      ext_tags[k]  = tags[k];
    end
    ext_slots[D+1] = '0;
    ext_tags[D+1]  = '0;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int k = 1; k <= D; k++) begin
        slots[k] <= '0;
        tags[k]  <= '0;
      end
    end else begin
      for (int k = 1; k <= D; k++) begin
        if (ins_en && (int'(ins_lat) == k)) begin
          slots[k] <= ins_slot;
          tags[k]  <= ins_tag;
        end else begin
          slots[k] <= ext_slots[k+1];
          tags[k]  <= ext_tags[k+1];
        end
      end
    end
  end

  // Slot L+1 now becomes slot L after the shift, so that is the one that must be empty.
  always_comb begin
    chk_free = 1'b1;
    for (int k = 1; k <= D + 1; k++) begin
      if (int'(chk_lat) + 1 == k) chk_free = !ext_slots[k].valid;
    end
  end

  always_comb begin
    any_valid = 1'b0;
    for (int k = 1; k <= D; k++) any_valid = any_valid | slots[k].valid;
  end

  assign head_slot = slots[1];
  assign head_tag  = tags[1];

endmodule

// File: rtl/fpu_wb_scheduler.sv
// FPU issue and writeback scheduler: accepts one op per cycle, reserves the
// shared writeback port per cycle and tracks the unpipelined divider.
module fpu_wb_scheduler
  import fpu_sched_pkg::*;
#(
  parameter int LAT_CMP = 1,
  parameter int LAT_ADD = 3,
  parameter int LAT_MUL = 2,
  parameter int LAT_DIV = 8,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             iss_valid,
  output logic [2:0]       iss_op,
  output logic             wb_valid,
  output logic [2:0]       wb_op,
  output logic [TAG_W-1:0] wb_tag,
  output logic             wb_illegal,
  output logic             busy
);

  localparam int D_AC = (LAT_ADD > LAT_CMP) ? LAT_ADD : LAT_CMP;
  localparam int D_MD = (LAT_MUL > LAT_DIV) ? LAT_MUL : LAT_DIV;
  localparam int D    = (D_AC > D_MD) ? D_AC : D_MD;

  logic             clr;
  logic [3:0]       lat;
  logic [3:0]       div_cnt;
  logic             div_free;
  logic             slot_free;
  logic             accept;
  slot_t            ins_slot;
  slot_t            head_slot;
  logic [TAG_W-1:0] head_tag;
  logic             any_valid;

  assign clr      = rst | flush;
  assign lat      = op_latency(in_op, LAT_CMP, LAT_ADD, LAT_MUL, LAT_DIV);
  assign div_free = (div_cnt <= 4'd1);

  assign in_ready  = !clr && slot_free && ((in_op != OP_FDIV) || div_free);
  assign accept    = in_valid && in_ready;
  assign iss_valid = accept && (in_op != OP_ILLEGAL);
  assign iss_op    = in_op;

  always_comb begin
    ins_slot         = '0;
    ins_slot.valid   = 1'b1;
    ins_slot.illegal = (in_op == OP_ILLEGAL);
    ins_slot.op      = in_op;
  end

  fpu_resv_ring #(
    .D     (D),
    .TAG_W (TAG_W)
  ) u_ring (
    .clk       (clk),
    .clr       (clr),
    .ins_en    (accept),
    .ins_lat   (lat),
    .ins_slot  (ins_slot),
    .ins_tag   (in_tag),
    .chk_lat   (lat),
    .chk_free  (slot_free),
    .head_slot (head_slot),
    .head_tag  (head_tag),
    .any_valid (any_valid)
  );

  // Divider stays occupied until its final cycle, which is when a new FDIV may enter.
  always_ff @(posedge clk) begin
    if (clr) begin
      div_cnt <= '0;
    end else if (accept && (in_op == OP_FDIV)) begin
      div_cnt <= 4'(LAT_DIV);
    end else if (div_cnt != 4'd0) begin
      div_cnt <= div_cnt - 4'd1;
    end
  end

  assign wb_valid   = head_slot.valid;
  assign wb_op      = head_slot.valid ? head_slot.op : 3'd0;
  assign wb_tag     = head_slot.valid ? head_tag : '0;
  assign wb_illegal = head_slot.valid & head_slot.illegal;

  assign busy = any_valid | (div_cnt != 4'd0);

endmodule

// File: tb/tb_fpu_wb_scheduler.sv
// Directed bench for fpu_wb_scheduler: expected writebacks are queued with
// their due cycle when an op is driven and matched against the wb port each cycle.
module tb_fpu_wb_scheduler;
  import fpu_sched_pkg::*;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_op;
  logic [4:0] in_tag;
  logic       iss_valid;
  logic [2:0] iss_op;
  logic       wb_valid;
  logic [2:0] wb_op;
  logic [4:0] wb_tag;
  logic       wb_illegal;
  logic       busy;

  typedef struct {
    int         cyc;
    logic [4:0] tag;
    logic [2:0] op;
    logic       ill;
  } exp_t;

  exp_t sbq[$];
  int   errors;
  int   checks;
  int   cyc;

  fpu_wb_scheduler #(
    .LAT_CMP (1),
    .LAT_ADD (3),
    .LAT_MUL (2),
    .LAT_DIV (8),
    .TAG_W   (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_tag     (in_tag),
    .iss_valid  (iss_valid),
    .iss_op     (iss_op),
    .wb_valid   (wb_valid),
    .wb_op      (wb_op),
    .wb_tag     (wb_tag),
    .wb_illegal (wb_illegal),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s cycle %0d: observed %0h expected %0h", name, cyc, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [4:0] tag,
                               input logic fl);
    in_valid = v;
    in_op    = op;
    in_tag   = tag;
    flush    = fl;
  endtask

  task automatic expectWb(input logic [4:0] tag, input logic [2:0] op, input logic ill,
                          input int lat);
    exp_t e;
    e.cyc = cyc + lat;
    e.tag = tag;
    e.op  = op;
    e.ill = ill;
    sbq.push_back(e);
  endtask

  // Move to the sampling point of the current cycle and settle any writeback due now.
  task automatic atNeg();
    int idx;
    idx = -1;
    @(negedge clk);
    foreach (sbq[i]) if (sbq[i].cyc == cyc) idx = i;
    if (idx >= 0) begin
      checkOutput("wb_valid", 32'(wb_valid), 32'd1);
      checkOutput("wb_tag", 32'(wb_tag), 32'(sbq[idx].tag));
      checkOutput("wb_op", 32'(wb_op), 32'(sbq[idx].op));
      checkOutput("wb_illegal", 32'(wb_illegal), 32'(sbq[idx].ill));
      sbq.delete(idx);
    end else begin
      checkOutput("wb_idle_valid", 32'(wb_valid), 32'd0);
      checkOutput("wb_idle_tag", 32'(wb_tag), 32'd0);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    applyStimulus(1'b0, OP_FADD, 5'd0, 1'b0);
    repeat (n) begin
      atNeg();
      nextCycle();
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc    = 0;

    // Reset held for two cycles with a request pending
    rst = 1'b1;
    applyStimulus(1'b1, OP_FADD, 5'd3, 1'b0);
    @(posedge clk);
    #1;
    repeat (2) begin
      atNeg();
      checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
      checkOutput("rst_iss_valid", 32'(iss_valid), 32'd0);
      checkOutput("rst_wb_op", 32'(wb_op), 32'd0);
      checkOutput("rst_wb_illegal", 32'(wb_illegal), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      nextCycle();
    end
    rst = 1'b0;
    for (int op = 0; op < 8; op++) begin
      applyStimulus(1'b0, 3'(op), 5'd0, 1'b0);
      #1;
      checkOutput("post_rst_ready", 32'(in_ready), 32'd1);
    end
    idle(1);

    // Single FADD: writeback three cycles later, nothing in between
    cyc = 0;
    $display("[TB] single FADD");
    applyStimulus(1'b1, OP_FADD, 5'd5, 1'b0);
    expectWb(5'd5, OP_FADD, 1'b0, 3);
    atNeg();
    checkOutput("fadd_ready", 32'(in_ready), 32'd1);
    checkOutput("fadd_iss_valid", 32'(iss_valid), 32'd1);
    checkOutput("fadd_iss_op", 32'(iss_op), 32'(OP_FADD));
    nextCycle();
    idle(5);

    // FMUL right after FADD would land on the same writeback cycle
    cyc = 0;
    $display("[TB] conflict");
    applyStimulus(1'b1, OP_FADD, 5'd1, 1'b0);
    expectWb(5'd1, OP_FADD, 1'b0, 3);
    atNeg();
    checkOutput("cf_fadd_ready", 32'(in_ready), 32'd1);
    nextCycle();
    applyStimulus(1'b1, OP_FMUL, 5'd2, 1'b0);
    atNeg();
    checkOutput("cf_fmul_stall", 32'(in_ready), 32'd0);
    checkOutput("cf_fmul_noiss", 32'(iss_valid), 32'd0);
    nextCycle();
    expectWb(5'd2, OP_FMUL, 1'b0, 2);
    atNeg();
    checkOutput("cf_fmul_ready", 32'(in_ready), 32'd1);
    checkOutput("cf_fmul_iss", 32'(iss_valid), 32'd1);
    nextCycle();
    idle(4);

    // Divider: second FDIV waits for the first to reach writeback
    cyc = 0;
    $display("[TB] divider");
    applyStimulus(1'b1, OP_FDIV, 5'd3, 1'b0);
    expectWb(5'd3, OP_FDIV, 1'b0, 8);
    atNeg();
    checkOutput("div1_ready", 32'(in_ready), 32'd1);
    nextCycle();
    applyStimulus(1'b1, OP_FISPOS, 5'd6, 1'b0);
    expectWb(5'd6, OP_FISPOS, 1'b0, 1);
    atNeg();
    checkOutput("fispos_ready", 32'(in_ready), 32'd1);
    checkOutput("fispos_iss_op", 32'(iss_op), 32'(OP_FISPOS));
    checkOutput("div_busy", 32'(busy), 32'd1);
    nextCycle();
    applyStimulus(1'b1, OP_FDIV, 5'd4, 1'b0);
    while (cyc < 8) begin
      atNeg();
      checkOutput("div2_stall", 32'(in_ready), 32'd0);
      nextCycle();
    end
    expectWb(5'd4, OP_FDIV, 1'b0, 8);
    atNeg();
    checkOutput("div2_ready", 32'(in_ready), 32'd1);
    checkOutput("div2_iss", 32'(iss_valid), 32'd1);
    nextCycle();
    idle(9);
    atNeg();
    checkOutput("div_idle_busy", 32'(busy), 32'd0);
    nextCycle();

    // Same-latency ops on consecutive cycles all go through
    cyc = 0;
    $display("[TB] back-to-back FMUL");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, OP_FMUL, 5'(10 + i), 1'b0);
      expectWb(5'(10 + i), OP_FMUL, 1'b0, 2);
      atNeg();
      checkOutput("b2b_ready", 32'(in_ready), 32'd1);
      nextCycle();
    end
    idle(4);

    // Illegal op: no unit strobe, flagged writeback next cycle
    cyc = 0;
    $display("[TB] illegal op");
    applyStimulus(1'b1, OP_ILLEGAL, 5'd9, 1'b0);
    expectWb(5'd9, OP_ILLEGAL, 1'b1, 1);
    atNeg();
    checkOutput("ill_ready", 32'(in_ready), 32'd1);
    checkOutput("ill_iss_valid", 32'(iss_valid), 32'd0);
    nextCycle();
    idle(2);

    // Flush drops the pending FADD and blocks acceptance in its cycle
    cyc = 0;
    $display("[TB] flush");
    applyStimulus(1'b1, OP_FADD, 5'd7, 1'b0);
    atNeg();
    checkOutput("fl_fadd_ready", 32'(in_ready), 32'd1);
    nextCycle();
    applyStimulus(1'b1, OP_FADD, 5'd8, 1'b1);
    atNeg();
    checkOutput("fl_ready", 32'(in_ready), 32'd0);
    checkOutput("fl_iss_valid", 32'(iss_valid), 32'd0);
    checkOutput("fl_busy_before", 32'(busy), 32'd1);
    nextCycle();
    applyStimulus(1'b0, OP_FADD, 5'd0, 1'b0);
    repeat (3) begin
      atNeg();
      checkOutput("fl_busy_after", 32'(busy), 32'd0);
      nextCycle();
    end

    checkOutput("sb_empty", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
